multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/mul_pkg.sv | 20 ++
 rtl/mul_sign_adj.sv | 13 +
 rtl/multiplier.sv | 118 +++++++++++
 tb/tb_multiplier.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants, control encodings and FSM state type for the
// sequential shift-add multiplier.
package mul_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] CTRL_MULTU = 5'd0;
  localparam logic [4:0] CTRL_MULT  = 5'd1;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  function automatic logic ctrl_valid(input logic [4:0] c);
    return (c == CTRL_MULTU) || (c == CTRL_MULT);
  endfunction

endpackage

// File: rtl/mul_sign_adj.sv
// Two's-complement conditional negate; yields an operand magnitude
// or applies the final sign to the product.
module mul_sign_adj #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_data,
  input  logic         i_neg,
  output logic [W-1:0] o_data
);

  assign o_data = i_neg ? (~i_data + W'(1)) : i_data;

endmodule

// File: rtl/multiplier.sv
// Radix-2 sequential multiplier: one multiplier bit per cycle through
// a single WIDTH-bit adder, signed mode via magnitude + final negate.
module multiplier #(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       ctrl,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             err
);

  import mul_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_err;

  logic               w_sgn;
  logic               w_valid;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_next;
  logic [2*WIDTH-1:0] w_res;
  logic               w_last;

  assign w_sgn   = (ctrl == CTRL_MULT);
  assign w_valid = ctrl_valid(ctrl);

  mul_sign_adj #(.W(WIDTH)) u_adj_a (
    .i_data (a),
    .i_neg  (w_sgn & a[WIDTH-1]),
    .o_data (w_mag_a)
  );

  mul_sign_adj #(.W(WIDTH)) u_adj_b (
    .i_data (b),
    .i_neg  (w_sgn & b[WIDTH-1]),
    .o_data (w_mag_b)
  );

  // Upper half accumulates; the multiplier shifts out of the low half.
  assign w_addend = r_prod[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_next   = {w_sum, r_prod[WIDTH-1:1]};
  assign w_last   = (r_count == CW'(WIDTH-1));

  mul_sign_adj #(.W(2*WIDTH)) u_adj_p (
    .i_data (w_next),
    .i_neg  (r_neg),
    .o_data (w_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && w_valid) begin
            r_state <= S_RUN;
            r_count <= '0;
            r_mcand <= w_mag_a;
            r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
            r_neg   <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          end else if (start) begin
            r_state <= S_DONE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_err   <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_prod  <= w_next;
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_state <= S_DONE;
            r_hi    <= w_res[2*WIDTH-1:WIDTH];
            r_lo    <= w_res[WIDTH-1:0];
            r_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign err  = r_err;
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_multiplier.sv
// Directed + random bench for the sequential multiplier against an
// arithmetic reference product.
module tb_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  ctrl;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        err;

  int total;
  int bad;

  multiplier #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ctrl  (ctrl),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [4:0]  c
  );
    logic [63:0] ux, uy;
    longint      sx, sy;
    ux = {32'd0, x};
    uy = {32'd0, y};
    sx = $signed(x);
    sy = $signed(y);
    if (c == 5'd0) return ux * uy;
    if (c == 5'd1) return 64'(sx * sy);
    return 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Call away from a clock edge; returns in the done cycle (or on timeout).
  task automatic op(input logic [31:0] x, input logic [31:0] y,
                    input logic [4:0] c, input string tag);
    logic [63:0] e;
    logic        ok;
    int          lat;
    ok = (c == 5'd0) || (c == 5'd1);
    e = ref_mul(x, y, c);
    a = x;
    b = y;
    ctrl = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    chk({tag, "_busy1"}, 64'(busy), 64'(ok));
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), ok ? 64'd33 : 64'd1);
    chk({tag, "_prod"}, {hi, lo}, e);
    chk({tag, "_err"}, 64'(err), 64'(!ok));
    chk({tag, "_busyd"}, 64'(busy), 64'd0);
  endtask

  task automatic step_idle(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [4:0]  c;
    int          lat;
    int          ndone;

    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    ctrl = '0;
    total = 0;
    bad = 0;

    #12;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    op(32'd11, 32'd2, 5'd0, "u11x2");
    chk("u11x2_exact", {hi, lo}, 64'd22);
    step_idle("u11x2");
    op(32'hFFFFFFFD, 32'd7, 5'd1, "sm3x7");
    chk("sm3x7_exact", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    step_idle("sm3x7");
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, "umax");
    chk("umax_exact", {hi, lo}, 64'hFFFFFFFE_00000001);
    op(32'h80000000, 32'h80000000, 5'd1, "smin");
    chk("smin_exact", {hi, lo}, 64'h40000000_00000000);
    op(32'd0, 32'h80000005, 5'd1, "szero");
    chk("szero_exact", {hi, lo}, 64'd0);
    op(32'h7FFFFFFF, 32'h80000000, 5'd1, "smix");
    step_idle("smix");

    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = $urandom;
      c = 5'($urandom_range(0, 1));
      op(x, y, c, $sformatf("rnd%0d", i));
    end
    step_idle("rnd");

    // start while busy must not disturb the running operation
    a = 32'd100;
    b = 32'd200;
    ctrl = 5'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    repeat (9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    a = 32'd7;
    b = 32'd9;
    ctrl = 5'd1;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("busy_lat", 64'(lat), 64'd33);
    chk("busy_prod", {hi, lo}, 64'd20000);
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("busy_nodone2", 64'(ndone), 64'd0);

    // reset in the middle of an operation
    a = 32'd123;
    b = 32'd456;
    ctrl = 5'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("mid_hold", {hi, lo}, 64'd20000);
    chk("mid_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_hilo", {hi, lo}, 64'd0);
    chk("arst_flags", {61'd0, busy, done, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("arst_nodone", 64'(ndone), 64'd0);
    op(32'd5, 32'd6, 5'd0, "post_rst");
    chk("post_rst_exact", {hi, lo}, 64'd30);
    step_idle("post_rst");

    // invalid ctrl, then back-to-back valid op from DONE
    op(32'd9, 32'd9, 5'd4, "inval");
    op(32'd1234, 32'hFFFFFFFE, 5'd0, "b2b");
    step_idle("b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
